// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared constants for the ULPI register engine.
//   - TXCMD command prefixes and the extended-address escape code
//   - FSM state encoding and ERR_CODE values
//   - helper that decides whether an address needs the extended sequence
package ulpi_pkg;

  localparam logic [1:0] REG_WRITE_CMD = 2'b10;
  localparam logic [1:0] REG_READ_CMD  = 2'b11;
  localparam logic [5:0] EXT_ADDR      = 6'h2F;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ABORT   = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_TXCMD      = 4'd1,
    ST_EXTADDR    = 4'd2,
    ST_WDATA      = 4'd3,
    ST_STOP       = 4'd4,
    ST_RD_TURN    = 4'd5,
    ST_RD_DATA    = 4'd6,
    ST_RD_END     = 4'd7,
    ST_ABORT_WAIT = 4'd8,
    ST_TO_STOP    = 4'd9
  } state_t;

  // Only an 8-bit build can reach registers above the immediate range;
  // everything above 8'h2E goes through the 6'h2F escape.
  function automatic logic needs_ext(input logic [7:0] addr, input int addr_w);
    return (addr_w == 8) && (addr > 8'h2E);
  endfunction

endpackage

// File: rtl/ulpi_timeout.sv
// ulpi_timeout: per-attempt watchdog, implemented as a down-counter.
//   clk, rst     : clock, synchronous active-low reset
//   clr          : reload the counter (start of a fresh attempt)
//   en           : count this cycle
//   expired      : terminal count reached (last allowed cycle of the attempt)
module ulpi_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Loaded with TIMEOUT_CYCLES-1 so that expiry is flagged in the
  // TIMEOUT_CYCLES-th cycle of the attempt (attempt cycle 0 = first TXCMD).
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= LOAD;
    end else if (clr) begin
      count <= LOAD;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ulpi_reg_access.sv
// ulpi_reg_access: ULPI PHY register read/write engine.
//   Request side : REQ/WE/ADDR/WDATA in, RDATA/BUSY/DONE/ERR/ERR_CODE out
//   ULPI side    : DIR/NXT/ULPI_DATA_I in, STP/ULPI_DATA_O/ULPI_DATA_OE out
//   clk, rst     : 60 MHz ULPI clock, synchronous active-low reset
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | waiting for REQ with DIR low
// TXCMD       | driving register command + 6-bit address
// EXTADDR     | driving full 8-bit address (extended access)
// WDATA       | driving write data
// STOP        | STP high for one cycle, DONE follows
// RD_TURN     | bus turnaround, link released
// RD_DATA     | PHY presents read data
// RD_END      | waiting for PHY to drop DIR
// ABORT_WAIT  | PHY took the bus; wait for release then retry or fail
// TO_STOP     | timeout while link owned the bus: one STP cycle, then ERR
module ulpi_reg_access
  import ulpi_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              REQ,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        WDATA,
  output logic [7:0]        RDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [1:0]        ERR_CODE,
  input  logic              DIR,
  input  logic              NXT,
  output logic              STP,
  output logic [7:0]        ULPI_DATA_O,
  output logic              ULPI_DATA_OE,
  input  logic [7:0]        ULPI_DATA_I
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  state_t        state, state_nxt;
  logic          we_q;
  logic [7:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [RW-1:0] retry_q;

  logic is_ext, retry_ok, expired, tmo_hit, oe_int, accept;
  logic done_set, err_tmo, err_abort, retry_go, capture;

  assign is_ext   = needs_ext(addr_q, ADDR_W);
  assign retry_ok = (retry_q < RETRY_LIM);
  assign tmo_hit  = expired && (state != ST_IDLE) && (state != ST_TO_STOP);
  assign accept   = (state == ST_IDLE) && REQ && !DIR;

  ulpi_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state == ST_IDLE) || retry_go),
    .en      (state != ST_IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tmo_hit) begin
      // STP only makes sense if the link still owns the bus.
      if ((state == ST_TXCMD || state == ST_EXTADDR || state == ST_WDATA) && !DIR)
        state_nxt = ST_TO_STOP;
      else
        state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       if (accept) state_nxt = ST_TXCMD;
        ST_TXCMD: begin
          if (DIR)      state_nxt = ST_ABORT_WAIT;
          else if (NXT) state_nxt = is_ext ? ST_EXTADDR : (we_q ? ST_WDATA : ST_RD_TURN);
        end
        ST_EXTADDR: begin
          if (DIR)      state_nxt = ST_ABORT_WAIT;
          else if (NXT) state_nxt = we_q ? ST_WDATA : ST_RD_TURN;
        end
        ST_WDATA:      if (NXT) state_nxt = ST_STOP;
        ST_STOP:       state_nxt = ST_IDLE;
        ST_RD_TURN: begin
          if (DIR && NXT) state_nxt = ST_ABORT_WAIT;
          else if (DIR)   state_nxt = ST_RD_DATA;
        end
        ST_RD_DATA:    state_nxt = DIR ? ST_RD_END : ST_ABORT_WAIT;
        ST_RD_END:     if (!DIR) state_nxt = ST_IDLE;
        ST_ABORT_WAIT: if (!DIR) state_nxt = retry_ok ? ST_TXCMD : ST_IDLE;
        ST_TO_STOP:    state_nxt = ST_IDLE;
        default:       state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    STP         = 1'b0;
    ULPI_DATA_O = 8'h00;
    oe_int      = 1'b0;
    case (state)
      ST_TXCMD: begin
        oe_int      = 1'b1;
        ULPI_DATA_O = {we_q ? REG_WRITE_CMD : REG_READ_CMD, is_ext ? EXT_ADDR : addr_q[5:0]};
      end
      ST_EXTADDR: begin
        oe_int      = 1'b1;
        ULPI_DATA_O = addr_q;
      end
      ST_WDATA: begin
        oe_int      = 1'b1;
        ULPI_DATA_O = wdata_q;
      end
      ST_STOP, ST_TO_STOP: begin
        oe_int = 1'b1;
        STP    = 1'b1;
      end
      default: ;
    endcase
    done_set  = !tmo_hit && ((state == ST_STOP) || (state == ST_RD_END && !DIR));
    err_tmo   = (state == ST_TO_STOP) || (tmo_hit && state_nxt == ST_IDLE);
    err_abort = !tmo_hit && (state == ST_ABORT_WAIT) && !DIR && !retry_ok;
    retry_go  = !tmo_hit && (state == ST_ABORT_WAIT) && !DIR && retry_ok;
    capture   = !tmo_hit && (state == ST_RD_DATA) && DIR;
  end

  // DIR high means the PHY owns the bus this very cycle.
  assign ULPI_DATA_OE = oe_int && !DIR;
  assign BUSY         = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      RDATA    <= 8'h00;
      ERR_CODE <= ERR_NONE;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      retry_q  <= '0;
    end else begin
      DONE <= done_set;
      ERR  <= err_tmo || err_abort;
      if (accept) begin
        we_q     <= WE;
        addr_q   <= 8'(ADDR);
        wdata_q  <= WDATA;
        retry_q  <= '0;
        ERR_CODE <= ERR_NONE;
      end
      if (retry_go) retry_q <= retry_q + 1'b1;
      if (capture)  RDATA <= ULPI_DATA_I;
      if (err_tmo)
        ERR_CODE <= ERR_TIMEOUT;
      else if (err_abort)
        ERR_CODE <= ERR_ABORT;
    end
  end

endmodule

// File: tb/tb_ulpi_reg_access.sv
module tb_ulpi_reg_access;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       REQ = 1'b0;
  logic       WE = 1'b0;
  logic [7:0] ADDR = 8'h00;
  logic [7:0] WDATA = 8'h00;
  logic       DIR = 1'b0;
  logic       NXT = 1'b0;
  logic [7:0] DATA_I = 8'h00;

  logic [7:0] rdata6, do6, rdata8, do8;
  logic       busy6, done6, err6, stp6, oe6;
  logic       busy8, done8, err8, stp8, oe8;
  logic [1:0] ec6, ec8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ulpi_reg_access #(.ADDR_W(6), .TIMEOUT_CYCLES(16), .MAX_RETRY(3)) dut6 (
    .clk(clk), .rst(rst), .REQ(REQ), .WE(WE), .ADDR(ADDR[5:0]), .WDATA(WDATA),
    .RDATA(rdata6), .BUSY(busy6), .DONE(done6), .ERR(err6), .ERR_CODE(ec6),
    .DIR(DIR), .NXT(NXT), .STP(stp6), .ULPI_DATA_O(do6), .ULPI_DATA_OE(oe6),
    .ULPI_DATA_I(DATA_I)
  );

  ulpi_reg_access #(.ADDR_W(8), .TIMEOUT_CYCLES(16), .MAX_RETRY(3)) dut8 (
    .clk(clk), .rst(rst), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(rdata8), .BUSY(busy8), .DONE(done8), .ERR(err8), .ERR_CODE(ec8),
    .DIR(DIR), .NXT(NXT), .STP(stp8), .ULPI_DATA_O(do8), .ULPI_DATA_OE(oe8),
    .ULPI_DATA_I(DATA_I)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    REQ = 1'b1; WE = we; ADDR = addr; WDATA = wd;
    tick();
    REQ = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    check("rst_rdata", rdata6, 8'h00);
    check("rst_errcode", {6'd0, ec6}, 8'h00);
    check("rst_busy", {7'd0, busy6}, 8'h00);
    check("rst_done_err", {6'd0, done6, err6}, 8'h00);
    check("rst_stp_oe", {6'd0, stp6, oe6}, 8'h00);
    check("rst_data_o", do6, 8'h00);
    rst = 1'b1;
    tick();

    // immediate write, NXT one cycle after each drive
    issue(1'b1, 8'h04, 8'h45);
    check("wr_txcmd", do6, 8'h84);
    check("wr_oe", {7'd0, oe6}, 8'h01);
    check("wr_busy", {7'd0, busy6}, 8'h01);
    tick(); check("wr_txcmd_hold", do6, 8'h84); NXT = 1'b1;
    tick(); check("wr_data", do6, 8'h45); NXT = 1'b0;
    tick(); NXT = 1'b1;
    tick(); NXT = 1'b0;
    check("wr_stp", {7'd0, stp6}, 8'h01);
    check("wr_stp_data", do6, 8'h00);
    check("wr_no_early_done", {7'd0, done6}, 8'h00);
    tick();
    check("wr_done", {7'd0, done6}, 8'h01);
    check("wr_no_err", {7'd0, err6}, 8'h00);
    check("wr_stp_one", {7'd0, stp6}, 8'h00);
    check("wr_busy_end", {7'd0, busy6}, 8'h00);
    tick(); check("wr_done_pulse", {7'd0, done6}, 8'h00);

    // immediate read returning 8'h24
    issue(1'b0, 8'h00, 8'h00);
    check("rd_txcmd", do6, 8'hC0);
    NXT = 1'b1;
    tick(); check("rd_turn_oe", {7'd0, oe6}, 8'h00);
    NXT = 1'b0; DIR = 1'b1; DATA_I = 8'h24;
    tick();
    tick(); DIR = 1'b0;
    check("rd_rdata", rdata6, 8'h24);
    check("rd_no_early_done", {7'd0, done6}, 8'h00);
    tick();
    check("rd_done", {7'd0, done6}, 8'h01);
    check("rd_busy_end", {7'd0, busy6}, 8'h00);
    tick();

    // timeout: NXT never arrives, STP at TXCMD+16, ERR one cycle later
    issue(1'b1, 8'h01, 8'h00);
    check("to_txcmd", do6, 8'h81);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("to_no_stp", {6'd0, stp6, err6}, 8'h00);
    end
    tick();
    check("to_stp", {7'd0, stp6}, 8'h01);
    check("to_stp_oe", {7'd0, oe6}, 8'h01);
    tick();
    check("to_err", {7'd0, err6}, 8'h01);
    check("to_code", {6'd0, ec6}, 8'h01);
    check("to_busy", {7'd0, busy6}, 8'h00);
    check("to_no_done", {7'd0, done6}, 8'h00);
    check("to_stp_end", {7'd0, stp6}, 8'h00);
    check("to_rdata_kept", rdata6, 8'h24);
    tick();
    check("to_err_pulse", {7'd0, err6}, 8'h00);
    check("to_code_hold", {6'd0, ec6}, 8'h01);

    // two PHY aborts during TXCMD, then accepted
    issue(1'b1, 8'h05, 8'hA5);
    for (int k = 0; k < 2; k++) begin
      check("ab_txcmd", do6, 8'h85);
      DIR = 1'b1; #1;
      check("ab_oe_drop", {7'd0, oe6}, 8'h00);
      tick(); DIR = 1'b0;
      tick();
    end
    check("ab_reissue", do6, 8'h85);
    check("ab_reissue_oe", {7'd0, oe6}, 8'h01);
    check("ab_code_clr", {6'd0, ec6}, 8'h00);
    NXT = 1'b1;
    tick(); check("ab_data", do6, 8'hA5);
    tick(); NXT = 1'b0;
    check("ab_stp", {7'd0, stp6}, 8'h01);
    tick();
    check("ab_done_err", {6'd0, done6, err6}, 8'h02);
    tick();

    // REQ held while DIR high, then four aborts exceed the retry limit
    DIR = 1'b1; REQ = 1'b1; WE = 1'b0; ADDR = 8'h07;
    tick(); tick();
    check("hold_wait", {7'd0, busy6}, 8'h00);
    DIR = 1'b0;
    tick(); REQ = 1'b0;
    check("hold_accept", {7'd0, busy6}, 8'h01);
    for (int k = 0; k < 4; k++) begin
      check("lim_txcmd", do6, 8'hC7);
      DIR = 1'b1;
      tick(); DIR = 1'b0;
      tick();
    end
    check("lim_err", {7'd0, err6}, 8'h01);
    check("lim_code", {6'd0, ec6}, 8'h02);
    check("lim_no_done", {7'd0, done6}, 8'h00);
    check("lim_busy", {7'd0, busy6}, 8'h00);
    tick();
    check("lim_err_pulse", {7'd0, err6}, 8'h00);

    // extended read on the 8-bit build
    issue(1'b0, 8'h3A, 8'h00);
    check("ext_txcmd", do8, 8'hEF);
    check("ext_txcmd_oe", {7'd0, oe8}, 8'h01);
    NXT = 1'b1;
    tick(); check("ext_addr", do8, 8'h3A);
    tick(); NXT = 1'b0; DIR = 1'b1; DATA_I = 8'h5C;
    check("ext_turn_oe", {7'd0, oe8}, 8'h00);
    tick();
    tick(); DIR = 1'b0;
    check("ext_rdata", rdata8, 8'h5C);
    tick();
    check("ext_done", {7'd0, done8}, 8'h01);
    check("ext_no_err", {7'd0, err8}, 8'h00);
    check("ext_stp", {7'd0, stp8}, 8'h00);
    check("ext_code", {6'd0, ec8}, 8'h00);
    check("ext_busy", {7'd0, busy8}, 8'h00);
    tick();

    // reset in the middle of WDATA
    issue(1'b1, 8'h02, 8'h33);
    NXT = 1'b1;
    tick(); NXT = 1'b0;
    check("rstm_data", do6, 8'h33);
    check("rstm_oe", {7'd0, oe6}, 8'h01);
    rst = 1'b0;
    tick();
    check("rstm_oe_drop", {7'd0, oe6}, 8'h00);
    check("rstm_stp", {7'd0, stp6}, 8'h00);
    check("rstm_busy", {7'd0, busy6}, 8'h00);
    check("rstm_no_pulse", {6'd0, done6, err6}, 8'h00);
    rst = 1'b1;
    tick();
    check("rstm_after", {6'd0, done6, err6}, 8'h00);
    tick();
    check("rstm_after2", {6'd0, done6, err6}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
